// File: rtl/gshare_branch_predictor.sv
// gshare branch predictor: 2-bit saturating-counter PHT indexed by PC xor global
// history, plus a direct-mapped BTB. The prediction is combinational from if_pc;
// training from EX takes effect on the rising edge.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   if_pc               fetch PC
//   pred_taken          predicted taken (BTB hit and (jump or counter msb))
//   pred_next_pc        BTB target when predicted taken, else if_pc + 4
//   pred_index          PHT index used, travels with the instruction
//   update_*            resolved control-flow outcome from EX
module gshare_branch_predictor #(
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned HIST_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           if_pc,
    output logic                  pred_taken,
    output logic [31:0]           pred_next_pc,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_is_branch,
    input  logic                  update_is_jump,
    input  logic                  update_taken,
    input  logic [31:0]           update_target
);

    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

    logic [1:0]            pht        [ENTRIES];
    logic                  btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0]   btb_tag    [ENTRIES];
    logic [31:0]           btb_target [ENTRIES];
    logic                  btb_jump   [ENTRIES];
    logic [HIST_BITS-1:0]  bhr;

    // Word-offset bits of the PCs carry no information for indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], update_pc[1:0]};

    // Fetch-side lookup.
    logic [INDEX_BITS-1:0] fetch_slot;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic                  fetch_hit;

    assign fetch_slot   = if_pc[INDEX_BITS+1:2];
    assign fetch_tag    = if_pc[31:INDEX_BITS+2];
    assign pred_index   = fetch_slot ^ INDEX_BITS'(bhr);
    assign fetch_hit    = btb_valid[fetch_slot] && (btb_tag[fetch_slot] == fetch_tag);
    assign pred_taken   = fetch_hit && (btb_jump[fetch_slot] || pht[pred_index][1]);
    assign pred_next_pc = pred_taken ? btb_target[fetch_slot] : (if_pc + 32'd4);

    // Update decode; a record flagged both branch and jump trains as a jump.
    logic                  upd_jump;
    logic                  upd_branch;
    logic                  btb_write;
    logic [INDEX_BITS-1:0] upd_slot;
    logic [1:0]            cnt_cur;
    logic [1:0]            cnt_next;

    assign upd_jump   = update_valid && update_is_jump;
    assign upd_branch = update_valid && update_is_branch && !update_is_jump;
    assign btb_write  = upd_jump || (upd_branch && update_taken);
    assign upd_slot   = update_pc[INDEX_BITS+1:2];
    assign cnt_cur    = pht[update_index];

    // Saturating step of the trained counter.
    always_comb begin
        cnt_next = cnt_cur;
        if (update_taken) begin
            if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'd1;
        end
    end

    // Counters, history and BTB valid bits; reset wins over any update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i]       <= 2'b01;
                btb_valid[i] <= 1'b0;
            end
            bhr <= '0;
        end else begin
            if (upd_branch) begin
                pht[update_index] <= cnt_next;
                bhr               <= HIST_BITS'({bhr, update_taken});
            end
            if (btb_write) begin
                btb_valid[upd_slot] <= 1'b1;
            end
        end
    end

    // BTB payload; meaningless while the valid bit is clear, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && btb_write) begin
            btb_tag[upd_slot]    <= update_pc[31:INDEX_BITS+2];
            btb_target[upd_slot] <= update_target;
            btb_jump[upd_slot]   <= update_is_jump;
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic [4:0]  pred_index;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [4:0]  update_index;
    logic        update_is_branch;
    logic        update_is_jump;
    logic        update_taken;
    logic [31:0] update_target;

    int n_tests = 0;
    int n_fail  = 0;

    gshare_branch_predictor #(.INDEX_BITS(5), .HIST_BITS(5)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_next_pc     (pred_next_pc),
        .pred_index       (pred_index),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_index     (update_index),
        .update_is_branch (update_is_branch),
        .update_is_jump   (update_is_jump),
        .update_taken     (update_taken),
        .update_target    (update_target)
    );

    always #5 clk = ~clk;

    // Reference model: counters as integers 0..3, history as an integer mod 32.
    int          m_cnt   [32];
    bit          m_valid [32];
    int unsigned m_tag   [32];
    int unsigned m_tgt   [32];
    bit          m_jump  [32];
    int unsigned m_bhr;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_cnt[i]   = 1;
            m_valid[i] = 1'b0;
        end
        m_bhr = 0;
    endfunction

    function automatic void model_predict(input int unsigned pc, output bit tk,
                                          output int unsigned npc, output int unsigned idx);
        int unsigned slot;
        slot = (pc / 4) % 32;
        idx  = slot ^ m_bhr;
        tk   = m_valid[slot] && (m_tag[slot] == pc / 128) && (m_jump[slot] || m_cnt[idx] >= 2);
        npc  = tk ? m_tgt[slot] : pc + 4;
    endfunction

    function automatic void model_update();
        bit jmp;
        bit br;
        int unsigned slot;
        if (reset) begin
            model_reset();
            return;
        end
        if (!update_valid) return;
        jmp  = update_is_jump;
        br   = update_is_branch && !update_is_jump;
        slot = (update_pc / 4) % 32;
        if (br) begin
            if (update_taken) m_cnt[update_index] = (m_cnt[update_index] == 3) ? 3 : m_cnt[update_index] + 1;
            else              m_cnt[update_index] = (m_cnt[update_index] == 0) ? 0 : m_cnt[update_index] - 1;
            m_bhr = (m_bhr * 2 + (update_taken ? 1 : 0)) % 32;
        end
        if (jmp || (br && update_taken)) begin
            m_valid[slot] = 1'b1;
            m_tag[slot]   = update_pc / 128;
            m_tgt[slot]   = update_target;
            m_jump[slot]  = update_is_jump;
        end
    endfunction

    task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic [4:0] uidx, input logic ubr, input logic ujmp,
                         input logic utk, input logic [31:0] utgt);
        if_pc            = pc;
        update_valid     = uv;
        update_pc        = upc;
        update_index     = uidx;
        update_is_branch = ubr;
        update_is_jump   = ujmp;
        update_taken     = utk;
        update_target    = utgt;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    bit          etk;
    int unsigned enpc;
    int unsigned eidx;

    task automatic test_reset();
        reset = 1'b1;
        drive(32'h100, 1'b1, 32'h100, 5'd0, 1'b1, 1'b0, 1'b1, 32'h80);
        clock_edge();
        clock_edge();
        reset = 1'b0;
        drive(32'h100, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pred_taken, pred_next_pc, pred_index} !== {1'b0, 32'h104, 5'h00}) begin
            n_fail++;
            $display("FAIL reset_pc100: got t=%0b npc=%h idx=%h want t=0 npc=00000104 idx=00",
                     pred_taken, pred_next_pc, pred_index);
        end
        drive(32'hFFFF_FFFC, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pred_taken, pred_next_pc, pred_index} !== {1'b0, 32'h0, 5'h1F}) begin
            n_fail++;
            $display("FAIL reset_wrap: got t=%0b npc=%h idx=%h want t=0 npc=00000000 idx=1f",
                     pred_taken, pred_next_pc, pred_index);
        end
    endtask

    task automatic test_branch_training();
        drive(32'h100, 1'b1, 32'h100, 5'h00, 1'b1, 1'b0, 1'b1, 32'h80);
        clock_edge();
        drive(32'h100, 1'b1, 32'h100, 5'h01, 1'b1, 1'b0, 1'b1, 32'h80);
        clock_edge();
        drive(32'h100, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pred_taken, pred_next_pc, pred_index} !== {1'b0, 32'h104, 5'h03}) begin
            n_fail++;
            $display("FAIL train_untrained: got t=%0b npc=%h idx=%h want t=0 npc=00000104 idx=03",
                     pred_taken, pred_next_pc, pred_index);
        end
        drive(32'h100, 1'b1, 32'h100, 5'h03, 1'b1, 1'b0, 1'b1, 32'h80);
        clock_edge();
        drive(32'h100, 1'b1, 32'h100, 5'h0F, 1'b1, 1'b0, 1'b1, 32'h80);
        clock_edge();
        drive(32'h100, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pred_taken, pred_next_pc, pred_index} !== {1'b1, 32'h80, 5'h0F}) begin
            n_fail++;
            $display("FAIL train_trained: got t=%0b npc=%h idx=%h want t=1 npc=00000080 idx=0f",
                     pred_taken, pred_next_pc, pred_index);
        end
    endtask

    task automatic test_saturation();
        bit exp_tk;
        logic [31:0] pc;
        // Fill every BTB slot with a conditional-branch entry of one tag.
        for (int i = 0; i < 32; i++) begin
            drive(32'h0, 1'b1, 32'h1000 + 32'(i * 4), 5'h1F, 1'b1, 1'b0, 1'b1, 32'h2000 + 32'(i * 4));
            clock_edge();
        end
        for (int k = 0; k < 9; k++) begin
            drive(32'h0, 1'b1, 32'h1000, 5'h07, 1'b1, 1'b0, (k < 4), 32'h2000);
            clock_edge();
            pc = 32'h1000 + 32'((7 ^ m_bhr) * 4);
            drive(pc, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
            exp_tk = (k < 5);
            n_tests++;
            if (pred_taken !== exp_tk || pred_index !== 5'h07) begin
                n_fail++;
                $display("FAIL saturate_step%0d: got t=%0b idx=%h want t=%0b idx=07",
                         k, pred_taken, pred_index, exp_tk);
            end
        end
    endtask

    task automatic test_jump();
        logic [4:0] b;
        b = 5'(m_bhr);
        drive(32'h0, 1'b1, 32'h200, 5'($urandom), 1'b0, 1'b1, 1'b1, 32'h400);
        clock_edge();
        drive(32'h200, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pred_taken, pred_next_pc, pred_index} !== {1'b1, 32'h400, b}) begin
            n_fail++;
            $display("FAIL jump_hit: got t=%0b npc=%h idx=%h want t=1 npc=00000400 idx=%h",
                     pred_taken, pred_next_pc, pred_index, b);
        end
        // Counter 7 was left at 0 and must not be moved by the jump.
        drive(32'h1000 + 32'({27'd0, 5'd7 ^ b} * 4), 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if (pred_taken !== 1'b0 || pred_index !== 5'h07) begin
            n_fail++;
            $display("FAIL jump_pht_untouched: got t=%0b idx=%h want t=0 idx=07", pred_taken, pred_index);
        end
    endtask

    task automatic test_alias();
        drive(32'h0, 1'b1, 32'h100, 5'($urandom), 1'b1, 1'b0, 1'b1, 32'h80);
        clock_edge();
        drive(32'h0, 1'b1, 32'h180, 5'($urandom), 1'b1, 1'b0, 1'b1, 32'h300);
        clock_edge();
        drive(32'h100, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pred_taken, pred_next_pc} !== {1'b0, 32'h104}) begin
            n_fail++;
            $display("FAIL alias_evicted: got t=%0b npc=%h want t=0 npc=00000104", pred_taken, pred_next_pc);
        end
        drive(32'h180, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        model_predict(if_pc, etk, enpc, eidx);
        n_tests++;
        if ({pred_taken, pred_next_pc, pred_index} !== {etk, enpc, 5'(eidx)}) begin
            n_fail++;
            $display("FAIL alias_new: got t=%0b npc=%h idx=%h want t=%0b npc=%h idx=%h",
                     pred_taken, pred_next_pc, pred_index, etk, enpc, 5'(eidx));
        end
    endtask

    task automatic test_same_cycle();
        drive(32'h3000, 1'b1, 32'h3000, 5'd0, 1'b0, 1'b1, 1'b1, 32'h5000);
        n_tests++;
        if ({pred_taken, pred_next_pc} !== {1'b0, 32'h3004}) begin
            n_fail++;
            $display("FAIL same_cycle_old: got t=%0b npc=%h want t=0 npc=00003004", pred_taken, pred_next_pc);
        end
        clock_edge();
        drive(32'h3000, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pred_taken, pred_next_pc} !== {1'b1, 32'h5000}) begin
            n_fail++;
            $display("FAIL same_cycle_new: got t=%0b npc=%h want t=1 npc=00005000", pred_taken, pred_next_pc);
        end
        reset = 1'b1;
        drive(32'h3000, 1'b1, 32'h3000, 5'd0, 1'b1, 1'b0, 1'b1, 32'h6000);
        clock_edge();
        reset = 1'b0;
        drive(32'h3000, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if ({pred_taken, pred_next_pc, pred_index} !== {1'b0, 32'h3004, 5'h00}) begin
            n_fail++;
            $display("FAIL reset_over_update: got t=%0b npc=%h idx=%h want t=0 npc=00003004 idx=00",
                     pred_taken, pred_next_pc, pred_index);
        end
    endtask

    task automatic test_random();
        logic [31:0] fpc;
        logic [31:0] upc;
        logic [4:0]  uidx;
        int          kind;
        bit          tkn;
        for (int n = 0; n < 400; n++) begin
            fpc  = {24'd0, 1'b0, ($urandom % 2 == 0), 6'd0} | {25'd0, 5'($urandom), 2'b00} | 32'h1000;
            upc  = {24'd0, 1'b0, ($urandom % 2 == 0), 6'd0} | {25'd0, 5'($urandom), 2'b00} | 32'h1000;
            kind = int'($urandom % 8);
            tkn  = (kind == 1 || kind == 2 || kind == 3) ? 1'b1 : 1'($urandom);
            model_predict(upc, etk, enpc, eidx);
            uidx = ($urandom % 2 == 0) ? 5'(eidx) : 5'($urandom);
            reset = ($urandom % 64 == 0);
            drive(fpc, ($urandom % 4 != 0), upc, uidx, (kind == 1 || kind >= 4),
                  (kind >= 1 && kind <= 3), tkn, $urandom & 32'hFFFF_FFFC);
            if (!reset) begin
                model_predict(if_pc, etk, enpc, eidx);
                n_tests++;
                if ({pred_taken, pred_next_pc, pred_index} !== {etk, enpc, 5'(eidx)}) begin
                    n_fail++;
                    $display("FAIL random_%0d: pc=%h got t=%0b npc=%h idx=%h want t=%0b npc=%h idx=%h",
                             n, if_pc, pred_taken, pred_next_pc, pred_index, etk, enpc, 5'(eidx));
                end
            end
            clock_edge();
        end
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        drive(32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        test_reset();
        test_branch_training();
        test_saturation();
        test_jump();
        test_alias();
        test_same_cycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
